press_generator: RTL

//  Timed button-press waveform generator; the drive end of the long-press interface.

---
 rtl/press_generator_pkg.sv | 16 +
 rtl/press_timer.sv | 18 +
 rtl/press_generator.sv | 76 +++++++
 3 files changed

// File: rtl/press_generator_pkg.sv
// press_generator_pkg: state encoding and cycle-count helpers shared by the press generator files
package press_generator_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PRESS = 2'd1, GAP = 2'd2} state_t;
  function automatic int ns2cyc(input int ns, input int period);
    return (ns / period < 1) ? 1 : ns / period;
  endfunction
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/press_timer.sv
// press_timer: loadable down-counter; expire flags the last counted cycle
module press_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             expire
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en) cnt <= cnt - CNT_W'(1);
  assign expire = cnt == CNT_W'(1);
endmodule

// File: rtl/press_generator.sv
// press_generator: timed short/long button-press generator with valid/ready request handshake.
// Define PRESS_GEN_QUEUE_EN to add a 1-entry request register accepting requests while busy.
module press_generator
  import press_generator_pkg::*;
#(
  parameter int CLK_PERIOD_ns  = 20,
  parameter int SHORT_TIMER_ns = 100,
  parameter int LONG_TIMER_ns  = 500,
  parameter int GAP_TIMER_ns   = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_long,
  output logic req_ready,
  output logic out,
  output logic busy,
  output logic done
);
  localparam int N_SHORT = ns2cyc(SHORT_TIMER_ns, CLK_PERIOD_ns);
  localparam int N_LONG  = ns2cyc(LONG_TIMER_ns, CLK_PERIOD_ns);
  localparam int N_GAP   = ns2cyc(GAP_TIMER_ns, CLK_PERIOD_ns);
  localparam int CNT_W   = clog2(max3(N_SHORT, N_LONG, N_GAP) + 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, load_val;
  logic load, expire, start, start_long;
`ifdef PRESS_GEN_QUEUE_EN
  logic q_full, q_long, accept;
  assign req_ready  = !q_full;
  assign accept     = req_valid && req_ready;
  assign start      = state == IDLE && (q_full || accept);
  assign start_long = q_full ? q_long : req_long;
  // an accept in IDLE with an empty slot starts directly; anything else parks in the slot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_full <= 1'b0;
      q_long <= 1'b0;
    end else if (accept && (state != IDLE || q_full)) begin
      q_full <= 1'b1;
      q_long <= req_long;
    end else if (state == IDLE && q_full) begin
      q_full <= 1'b0;
    end
`else
  assign req_ready  = state == IDLE;
  assign start      = state == IDLE && req_valid;
  assign start_long = req_long;
`endif
  always_comb begin
    load     = start || (state == PRESS && expire);
    load_val = start ? (start_long ? CNT_W'(N_LONG) : CNT_W'(N_SHORT)) : CNT_W'(N_GAP);
    state_n  = start ? PRESS :
               (state == PRESS && expire) ? GAP :
               (state == GAP && expire) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      out   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      out   <= state_n == PRESS;
      done  <= state == GAP && expire;
    end
  assign busy = state != IDLE;
  press_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (busy && cnt != '0),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .expire   (expire)
  );
endmodule
